// File: rtl/bs_result_writer.sv
// Round-robin result writer: drains NUM_ENG Black-Scholes engines into a circular result region.
// Optional RESULT_CHECKSUM_EN appends an XOR checksum write (WR_SUM) at batch completion.
module bs_result_writer #(
  parameter int          NUM_ENG        = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
  parameter int          REGION_ENTRIES = 64,
  parameter int          CNT_W          = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ENG-1:0]   result_valid,
  input  logic [NUM_ENG*32-1:0] result_id,
  input  logic [NUM_ENG*32-1:0] result_price,
  output logic [NUM_ENG-1:0]   result_ack,
  input  logic                 count_load,
  input  logic [CNT_W-1:0]     expected_count,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_data,
  output logic [CNT_W-1:0]     results_written,
  output logic                 all_done,
  output logic                 busy
);

  localparam int GW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [31:0] LAST_ADDR =
    BASE_ADDR + 32'(8 * (REGION_ENTRIES - 1));
`ifdef RESULT_CHECKSUM_EN
  localparam logic [31:0] SUM_ADDR =
    BASE_ADDR + 32'(8 * REGION_ENTRIES);
`endif

  typedef enum logic [1:0] {
    ARB,
    WR_ID,
    WR_PRICE
`ifdef RESULT_CHECKSUM_EN
    , WR_SUM
`endif
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_rr_last;
  logic [31:0]        r_id;
  logic [31:0]        r_price;
  logic [31:0]        r_wr_ptr;
  logic [CNT_W-1:0]   r_expected;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0]        r_sum;
`endif

  logic [GW-1:0]      w_grant;
  logic [GW-1:0]      w_idx;
  logic               w_any;
  logic [31:0]        w_id;
  logic [31:0]        w_price;
  logic [NUM_ENG-1:0] w_onehot;
  logic               w_done_hit;

  // Walk from farthest to nearest so the engine right after rr_last wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int i = NUM_ENG; i >= 1; i--) begin
      w_idx = GW'((int'(r_rr_last) + i) % NUM_ENG);
      if (result_valid[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
  end

  assign w_id     = result_id[w_grant*32 +: 32];
  assign w_price  = result_price[w_grant*32 +: 32];
  assign w_onehot = NUM_ENG'(1) << w_grant;
  assign w_done_hit = (r_expected != '0) &&
    ((results_written + CNT_W'(1)) == r_expected);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ARB;
      r_rr_last       <= GW'(NUM_ENG - 1);
      r_id            <= '0;
      r_price         <= '0;
      r_wr_ptr        <= BASE_ADDR;
      r_expected      <= '0;
      result_ack      <= '0;
      mem_en          <= 1'b0;
      mem_we          <= 4'h0;
      mem_addr        <= '0;
      mem_data        <= '0;
      results_written <= '0;
      all_done        <= 1'b0;
      busy            <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      r_sum           <= '0;
`endif
    end else begin
      unique case (r_state)
        ARB: begin
          mem_en     <= 1'b0;
          mem_we     <= 4'h0;
          result_ack <= '0;
          busy       <= 1'b0;
          if (count_load) begin
            r_expected      <= expected_count;
            results_written <= '0;
            all_done        <= 1'b0;
            r_wr_ptr        <= BASE_ADDR;
`ifdef RESULT_CHECKSUM_EN
            r_sum           <= '0;
`endif
          end
          if (w_any) begin
            r_id       <= w_id;
            r_price    <= w_price;
            r_rr_last  <= w_grant;
            result_ack <= w_onehot;
            mem_en     <= 1'b1;
            mem_we     <= 4'hF;
            mem_addr   <= count_load ? BASE_ADDR : r_wr_ptr;
            mem_data   <= w_id;
            busy       <= 1'b1;
            r_state    <= WR_ID;
          end
        end
        WR_ID: begin
          result_ack <= '0;
          mem_addr   <= r_wr_ptr + 32'd4;
          mem_data   <= r_price;
          r_state    <= WR_PRICE;
        end
        WR_PRICE: begin
          mem_en  <= 1'b0;
          mem_we  <= 4'h0;
          busy    <= 1'b0;
          r_state <= ARB;
          r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ?
            BASE_ADDR : r_wr_ptr + 32'd8;
          if (results_written != '1)
            results_written <= results_written + CNT_W'(1);
`ifdef RESULT_CHECKSUM_EN
          r_sum <= r_sum ^ r_id ^ r_price;
          if (w_done_hit) begin
            mem_en   <= 1'b1;
            mem_we   <= 4'hF;
            mem_addr <= SUM_ADDR;
            mem_data <= r_sum ^ r_id ^ r_price;
            busy     <= 1'b1;
            r_state  <= WR_SUM;
          end
`else
          if (w_done_hit)
            all_done <= 1'b1;
`endif
        end
`ifdef RESULT_CHECKSUM_EN
        WR_SUM: begin
          mem_en   <= 1'b0;
          mem_we   <= 4'h0;
          busy     <= 1'b0;
          all_done <= 1'b1;
          r_state  <= ARB;
        end
`endif
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_result_writer.sv
// Scoreboard bench for bs_result_writer: directed engine traffic, monitor checks every memory write.
// Expects the checksum write at 0x600 when RESULT_CHECKSUM_EN is defined.
module tb_bs_result_writer;

  localparam int NE = 4;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NE-1:0]   result_valid;
  logic [NE*32-1:0] result_id;
  logic [NE*32-1:0] result_price;
  logic [NE-1:0]   result_ack;
  logic            count_load;
  logic [CW-1:0]   expected_count;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_data;
  logic [CW-1:0]   results_written;
  logic            all_done;
  logic            busy;

  bs_result_writer #(
    .NUM_ENG(NE),
    .BASE_ADDR(32'h0000_0400),
    .REGION_ENTRIES(64),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .result_valid(result_valid),
    .result_id(result_id),
    .result_price(result_price),
    .result_ack(result_ack),
    .count_load(count_load),
    .expected_count(expected_count),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .results_written(results_written),
    .all_done(all_done),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ack;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  logic [31:0] e_id [NE][256];
  logic [31:0] e_pr [NE][256];
  int          e_head [NE];
  int          e_tail [NE];
  int          flush_req = 0;
  int          flush_seen = 0;
  logic [NE-1:0] ack_prev;
  logic [31:0] tb_sum;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit eng_busy();
    for (int k = 0; k < NE; k++)
      if (e_head[k] != e_tail[k] || result_valid[k]) return 1'b1;
    return 1'b0;
  endfunction

  // Engine model: holds valid until the ack cycle ends, then presents its next item.
  initial begin
    result_valid = '0;
    result_id    = '0;
    result_price = '0;
    ack_prev     = '0;
    for (int k = 0; k < NE; k++) e_head[k] = 0;
    forever begin
      @(posedge clock);
      #1;
      if (flush_seen != flush_req) begin
        flush_seen = flush_req;
        for (int k = 0; k < NE; k++) e_head[k] = e_tail[k];
        result_valid = '0;
        ack_prev = '0;
      end
      for (int k = 0; k < NE; k++) begin
        if (ack_prev[k] && result_valid[k]) begin
          e_head[k]++;
          result_valid[k] = 1'b0;
        end
        if (!result_valid[k] && e_head[k] != e_tail[k]) begin
          result_id[k*32 +: 32]    = e_id[k][e_head[k]];
          result_price[k*32 +: 32] = e_pr[k][e_head[k]];
          result_valid[k] = 1'b1;
        end
      end
      ack_prev = result_ack;
    end
  end

  // Monitor: every memory write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (mem_en === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                   mem_addr, mem_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_data, e.data);
          chk("wr_we", {28'd0, mem_we}, 32'hF);
          chk("wr_ack", {28'd0, result_ack}, {28'd0, e.ack});
        end
      end else begin
        chk("idle_ack", {28'd0, result_ack}, 32'd0);
      end
    end
  end

  task automatic push(input int k, input logic [31:0] id,
                      input logic [31:0] pr, input logic [31:0] addr);
    e_id[k][e_tail[k]] = id;
    e_pr[k][e_tail[k]] = pr;
    e_tail[k]++;
    exp_q.push_back({addr, id, 4'(1 << k)});
    exp_q.push_back({addr + 32'd4, pr, 4'h0});
    tb_sum = tb_sum ^ id ^ pr;
  endtask

  task automatic exp_sum();
`ifdef RESULT_CHECKSUM_EN
    exp_q.push_back({32'h0000_0600, tb_sum, 4'h0});
`endif
  endtask

  task automatic load(input logic [CW-1:0] n);
    @(negedge clock);
    count_load = 1'b1;
    expected_count = n;
    @(negedge clock);
    count_load = 1'b0;
    tb_sum = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || eng_busy()) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    flush_req++;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    tb_sum = '0;
    @(negedge clock);
  endtask

  initial begin
    int found;
    count_load = 1'b0;
    expected_count = '0;
    tb_sum = '0;
    for (int k = 0; k < NE; k++) e_tail[k] = 0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_ack", {28'd0, result_ack}, 32'd0);
    chk("rst_written", {16'd0, results_written}, 32'd0);
    chk("rst_done", {31'd0, all_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // single result from engine 2
    load(16'd1);
    push(2, 32'h1234_5679, 32'h40A0_0000, 32'h400);
    exp_sum();
    drain("single");
    chk("single_written", {16'd0, results_written}, 32'd1);
    chk("single_done", {31'd0, all_done}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);

    // result after batch completion is still written and counted
    push(0, 32'h0000_0002, 32'h3F80_0000, 32'h408);
    drain("late");
    chk("late_written", {16'd0, results_written}, 32'd2);
    chk("late_done", {31'd0, all_done}, 32'd1);

    // all four engines valid together after reset
    do_reset();
    load(16'd4);
    first_wr = -1;
    for (int k = 0; k < NE; k++)
      push(k, 32'h100 + k, 32'h4000_0000 + k, 32'h400 + 8 * k);
    exp_sum();
    drain("rr");
`ifdef RESULT_CHECKSUM_EN
    chk("rr_span", last_wr - first_wr, 32'd11);
`else
    chk("rr_span", last_wr - first_wr, 32'd10);
`endif
    chk("rr_written", {16'd0, results_written}, 32'd4);
    chk("rr_done", {31'd0, all_done}, 32'd1);

    // engines 0 and 1 continuously valid alternate
    load(16'd6);
    for (int j = 0; j < 3; j++) begin
      push(0, 32'hA0 + j, 32'h3F00_0000 + j, 32'h400 + 16 * j);
      push(1, 32'hB0 + j, 32'h3E00_0000 + j, 32'h408 + 16 * j);
    end
    exp_sum();
    drain("fair");
    chk("fair_written", {16'd0, results_written}, 32'd6);
    chk("fair_done", {31'd0, all_done}, 32'd1);

    // wrap-around of the 64-entry region
    load(16'd66);
    for (int i = 0; i < 66; i++)
      push(3, 32'h1000 + i, 32'h2000_0000 + i, 32'h400 + 8 * (i % 64));
    exp_sum();
    drain("wrap");
    chk("wrap_written", {16'd0, results_written}, 32'd66);
    chk("wrap_done", {31'd0, all_done}, 32'd1);

    // count_load during WR_ID must be ignored
    load(16'd2);
    push(1, 32'h55, 32'h66, 32'h400);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clock);
      #2;
      if (mem_en && mem_addr == 32'h400 && result_ack[1]) found = 1;
    end
    chk("cl_wr_id_seen", found, 32'd1);
    if (found != 0) begin
      count_load = 1'b1;
      expected_count = 16'd5;
      @(negedge clock);
      #2;
      count_load = 1'b0;
      expected_count = 16'd2;
    end
    push(1, 32'h77, 32'h88, 32'h408);
    exp_sum();
    drain("cl");
    chk("cl_written", {16'd0, results_written}, 32'd2);
    chk("cl_done", {31'd0, all_done}, 32'd1);

    // reset asserted during WR_PRICE
    load(16'd3);
    push(0, 32'hDEAD_0001, 32'h4049_0FDB, 32'h400);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clock);
      #2;
      if (mem_en && mem_addr == 32'h404) found = 1;
    end
    chk("rstmid_price_seen", found, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rstmid_ack", {28'd0, result_ack}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_queue", exp_q.size(), 32'd0);
    exp_q.delete();
    flush_req++;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    tb_sum = '0;
    @(negedge clock);
    chk("rstmid_written", {16'd0, results_written}, 32'd0);
    chk("rstmid_done", {31'd0, all_done}, 32'd0);
    repeat (5) @(negedge clock);
    load(16'd1);
    push(1, 32'h0000_0009, 32'h0000_000A, 32'h400);
    exp_sum();
    drain("post");
    chk("post_written", {16'd0, results_written}, 32'd1);
    chk("post_done", {31'd0, all_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
